vga_cfg_axil_slave: RTL and testbench
=====================================

# vga_cfg_axil_slave

AXI4-Lite responder exposing the VGA configuration/status register bank to a host CPU or debug master, clocked by clk_100m_i. It is the target side of the same AXI4-Lite protocol vga_clk_gen drives as an initiator toward the clocking wizard. It turns host writes into a resolution select and a one-cycle reconfiguration request for vga_clk_gen, and reports completion back through a status register.

## Interface
- ADDR_W, 11, AXI address width; only bits [3:2] are decoded, other bits must be zero.
- DATA_W, 32, AXI data width; fixed at 32.
- clk_100m_i  in  1  system clock.
- arstn_i  in  1  asynchronous, active-low reset.
- s_axi_awaddr_i/awvalid_i/awready_o  in/in/out  ADDR_W/1/1  write address channel.
- s_axi_wdata_i/wstrb_i/wvalid_i/wready_o  in/in/in/out  32/4/1/1  write data channel.
- s_axi_bresp_o/bvalid_o/bready_i  out/out/in  2/1/1  write response channel.
- s_axi_araddr_i/arvalid_i/arready_o  in/in/out  ADDR_W/1/1  read address channel.
- s_axi_rdata_o/rresp_o/rvalid_o/rready_i  out/out/out/in  32/2/1/1  read data channel.
- resolution_o  out  vga_resolution_e  selected resolution, to vga_clk_gen resolution_i.
- req_o  out  1  single-cycle reconfiguration pulse, to vga_clk_gen req_i.
- valid_i  in  1  completion pulse from vga_clk_gen valid_o.

## Operation
- Register map (byte offsets):
  - 0x0 CTRL, RW: [3:0] RES. A write with RES >= VGA_RES_NUM leaves the field unchanged and returns SLVERR.
  - 0x4 CMD, WO: writing 1 to bit0 while not BUSY pulses req_o and sets BUSY. A write while BUSY is dropped and returns SLVERR. Reads return 0.
  - 0x8 STATUS: [0] BUSY (RO), [1] DONE (sticky, W1C).
  - 0xC ID, RO: 32'h5647_4131. Writes return SLVERR.
- Unmapped address (any nonzero bit outside [3:2]): read data 0, rresp SLVERR; write has no effect, bresp SLVERR.
- wstrb: a field is updated only if its byte lane strobe is set. A write with wstrb[0]=0 to CTRL/CMD/STATUS is a no-op with OKAY.
- On valid_i: BUSY cleared, DONE set.
- Write FSM states:
  - W_IDLE: awready=wready=1. AW and W are captured independently, in any order or in the same cycle; each ready drops once its beat is captured.
  - W_RESP: entered when both beats are held. The register update happens on the entering edge. bvalid=1, held until bready; then return to W_IDLE.
- Read FSM states:
  - R_IDLE: arready=1. On arvalid, rdata is sampled from the current register values.
  - R_DATA: rvalid=1, rdata/rresp stable until rready; then return to R_IDLE.
- Write and read channels are independent. At most one outstanding transaction per direction.

## Timing
- Reset values: awready/wready/arready=1, bvalid=0, rvalid=0, bresp=rresp=0, rdata=0, req_o=0, resolution_o=VGA_RES_800_600, BUSY=0, DONE=0.
- AW and W both valid in cycle N: bvalid and register update visible in N+1; req_o high in N+1 only.
- AW in cycle N, W in N+k: bvalid in N+k+1.
- arvalid accepted in cycle N: rvalid in N+1.
- Same-cycle read and write accept: the read returns the pre-write value.
- valid_i coincident with a DONE W1C write: set wins, DONE=1.
- valid_i coincident with a CMD write: the write observes BUSY=1 (pre-clear) and is rejected.
- Reset asserted mid-transaction: all FSMs return to idle and outstanding responses are discarded. Registers and outputs take reset values asynchronously.
- vga_clk_gen samples resolution_i during its transfer. CTRL writes while BUSY are accepted but take effect only for the next request.

## Structure
- vga_pkg gains:
  - register offset localparams (VGA_REG_CTRL/CMD/STATUS/ID);
  - STATUS bit indices;
  - VGA_ID_VALUE;
  - an AXI resp typedef enum (OKAY=2'b00, SLVERR=2'b10).
- vga_resolution_e and VGA_RES_NUM are reused from vga_pkg.
- Single module, no sub-module; the write and read FSMs are two always_ff/always_comb pairs.

## Test plan
- Reset, then read 0xC -> rdata 32'h5647_4131, rresp OKAY, rvalid one cycle after arvalid.
- Write CTRL=1 with wstrb 4'hF, then read CTRL -> 1; resolution_o=VGA_RES_1280_1024. Write CTRL=4'hF -> bresp SLVERR, CTRL stays 1.
- Write CMD=1 -> req_o high exactly one cycle, STATUS=0x1. Second CMD write -> SLVERR, no pulse. Pulse valid_i -> STATUS=0x2. Write STATUS=0x2 -> STATUS=0x0.
- W beat 3 cycles before AW with bready held low 5 cycles -> bvalid asserted the cycle after AW and held until bready; awready/wready stay low meanwhile.
- Read 0x10 -> rdata 0, SLVERR. valid_i in the same cycle as a W1C of DONE -> DONE reads 1.
- Assert arstn_i while bvalid=1 -> bvalid=0 immediately, all readies=1, CTRL=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA types plus the register map of the AXI4-Lite configuration slave.
package vga_pkg;

  typedef enum logic [3:0] {
    VGA_RES_800_600   = 4'd0,
    VGA_RES_1280_1024 = 4'd1,
    VGA_RES_640_480   = 4'd2,
    VGA_RES_1024_768  = 4'd3
  } vga_resolution_e;

  localparam int unsigned VGA_RES_NUM = 4;

  // Register byte offsets; only address bits [3:2] select a register.
  localparam logic [3:0] VGA_REG_CTRL   = 4'h0;
  localparam logic [3:0] VGA_REG_CMD    = 4'h4;
  localparam logic [3:0] VGA_REG_STATUS = 4'h8;
  localparam logic [3:0] VGA_REG_ID     = 4'hC;

  localparam int unsigned VGA_STATUS_BUSY_BIT = 0;
  localparam int unsigned VGA_STATUS_DONE_BIT = 1;

  localparam logic [31:0] VGA_ID_VALUE = 32'h5647_4131;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_SLVERR = 2'b10
  } axi_resp_e;

endpackage

// File: rtl/vga_cfg_axil_slave.sv
// AXI4-Lite register bank: resolution select, reconfiguration command and
// completion status for vga_clk_gen.
module vga_cfg_axil_slave
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk_100m_i,
  input  logic                arstn_i,
  input  logic [ADDR_W-1:0]   s_axi_awaddr_i,
  input  logic                s_axi_awvalid_i,
  output logic                s_axi_awready_o,
  input  logic [DATA_W-1:0]   s_axi_wdata_i,
  input  logic [3:0]          s_axi_wstrb_i,
  input  logic                s_axi_wvalid_i,
  output logic                s_axi_wready_o,
  output logic [1:0]          s_axi_bresp_o,
  output logic                s_axi_bvalid_o,
  input  logic                s_axi_bready_i,
  input  logic [ADDR_W-1:0]   s_axi_araddr_i,
  input  logic                s_axi_arvalid_i,
  output logic                s_axi_arready_o,
  output logic [DATA_W-1:0]   s_axi_rdata_o,
  output logic [1:0]          s_axi_rresp_o,
  output logic                s_axi_rvalid_o,
  input  logic                s_axi_rready_i,
  output vga_resolution_e     resolution_o,
  output logic                req_o,
  input  logic                valid_i
);

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  wr_state_e         wr_state_q, wr_state_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  axi_resp_e         bresp_q, bresp_d;

  vga_resolution_e   res_q, res_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_q, req_d;

  rd_state_e         rd_state_q, rd_state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  axi_resp_e         rresp_q, rresp_d;

  logic              aw_fire, w_fire, wr_commit;
  logic [ADDR_W-1:0] awaddr_eff;
  logic [DATA_W-1:0] wdata_eff;
  logic [3:0]        wstrb_eff;
  logic [DATA_W-1:0] rd_data;
  axi_resp_e         rd_resp;
  logic              unused_wr_bits;

  function automatic logic addr_mapped(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] masked;
    masked      = addr;
    masked[3:2] = '0;
    return (masked == '0);
  endfunction

  assign s_axi_awready_o = (wr_state_q == W_IDLE) && !aw_held_q;
  assign s_axi_wready_o  = (wr_state_q == W_IDLE) && !w_held_q;
  assign s_axi_bvalid_o  = (wr_state_q == W_RESP);
  assign s_axi_bresp_o   = bresp_q;
  assign s_axi_arready_o = (rd_state_q == R_IDLE);
  assign s_axi_rvalid_o  = (rd_state_q == R_DATA);
  assign s_axi_rdata_o   = rdata_q;
  assign s_axi_rresp_o   = rresp_q;
  assign resolution_o    = res_q;
  assign req_o           = req_q;

  assign aw_fire    = s_axi_awvalid_i && s_axi_awready_o;
  assign w_fire     = s_axi_wvalid_i && s_axi_wready_o;
  // A beat arriving on the commit edge is used directly, not via its holding register.
  assign awaddr_eff = aw_held_q ? awaddr_q : s_axi_awaddr_i;
  assign wdata_eff  = w_held_q ? wdata_q : s_axi_wdata_i;
  assign wstrb_eff  = w_held_q ? wstrb_q : s_axi_wstrb_i;

  assign unused_wr_bits = ^{wdata_eff[DATA_W-1:4], wstrb_eff[3:1]};

  // Write FSM: collect AW and W independently, commit once both are present.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wr_commit  = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi_awaddr_i;
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi_wdata_i;
          wstrb_d  = s_axi_wstrb_i;
        end
        if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
          wr_state_d = W_RESP;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_commit  = 1'b1;
        end
      end
      W_RESP: if (s_axi_bready_i) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Register updates on write commit and on completion from vga_clk_gen.
  always_comb begin
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = done_q;
    req_d   = 1'b0;
    bresp_d = bresp_q;
    // BUSY is cleared before the write is decoded (which still checks busy_q),
    // DONE is set after it so a coincident W1C loses.
    if (valid_i) busy_d = 1'b0;
    if (wr_commit) begin
      bresp_d = AXI_RESP_OKAY;
      if (!addr_mapped(awaddr_eff)) begin
        bresp_d = AXI_RESP_SLVERR;
      end else begin
        case ({awaddr_eff[3:2], 2'b00})
          VGA_REG_CTRL: begin
            if (wstrb_eff[0]) begin
              if (32'(wdata_eff[3:0]) >= VGA_RES_NUM) bresp_d = AXI_RESP_SLVERR;
              else res_d = vga_resolution_e'(wdata_eff[3:0]);
            end
          end
          VGA_REG_CMD: begin
            if (wstrb_eff[0]) begin
              if (busy_q) begin
                bresp_d = AXI_RESP_SLVERR;
              end else if (wdata_eff[0]) begin
                busy_d = 1'b1;
                req_d  = 1'b1;
              end
            end
          end
          VGA_REG_STATUS: begin
            if (wstrb_eff[0] && wdata_eff[VGA_STATUS_DONE_BIT]) done_d = 1'b0;
          end
          default: bresp_d = AXI_RESP_SLVERR;
        endcase
      end
    end
    if (valid_i) done_d = 1'b1;
  end

  // Read data mux from the current (pre-update) register values.
  always_comb begin
    rd_data = '0;
    rd_resp = AXI_RESP_OKAY;
    if (!addr_mapped(s_axi_araddr_i)) begin
      rd_resp = AXI_RESP_SLVERR;
    end else begin
      case ({s_axi_araddr_i[3:2], 2'b00})
        VGA_REG_CTRL:   rd_data[3:0] = res_q;
        VGA_REG_STATUS: begin
          rd_data[VGA_STATUS_BUSY_BIT] = busy_q;
          rd_data[VGA_STATUS_DONE_BIT] = done_q;
        end
        VGA_REG_ID:     rd_data = VGA_ID_VALUE;
        default:        rd_data = '0;
      endcase
    end
  end

  // Read FSM: accept an address, hold the response until rready.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (s_axi_arvalid_i) begin
          rd_state_d = R_DATA;
          rdata_d    = rd_data;
          rresp_d    = rd_resp;
        end
      end
      R_DATA: if (s_axi_rready_i) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // State and register flops with asynchronous active-low reset.
  always_ff @(posedge clk_100m_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_state_q <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= AXI_RESP_OKAY;
      res_q      <= VGA_RES_800_600;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= AXI_RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      res_q      <= res_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      req_q      <= req_d;
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule

// File: tb/tb_vga_cfg_axil_slave.sv
// Directed and randomized bench for vga_cfg_axil_slave with a behavioural register model.
module tb_vga_cfg_axil_slave;
  import vga_pkg::*;

  logic            clk;
  logic            arstn;
  logic [10:0]     awaddr;
  logic            awvalid;
  logic            awready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [10:0]     araddr;
  logic            arvalid;
  logic            arready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;
  vga_resolution_e resolution;
  logic            req;
  logic            valid_in;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the register bank.
  logic [3:0] m_res;
  bit         m_busy;
  bit         m_done;

  vga_cfg_axil_slave #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk_100m_i      (clk),
    .arstn_i         (arstn),
    .s_axi_awaddr_i  (awaddr),
    .s_axi_awvalid_i (awvalid),
    .s_axi_awready_o (awready),
    .s_axi_wdata_i   (wdata),
    .s_axi_wstrb_i   (wstrb),
    .s_axi_wvalid_i  (wvalid),
    .s_axi_wready_o  (wready),
    .s_axi_bresp_o   (bresp),
    .s_axi_bvalid_o  (bvalid),
    .s_axi_bready_i  (bready),
    .s_axi_araddr_i  (araddr),
    .s_axi_arvalid_i (arvalid),
    .s_axi_arready_o (arready),
    .s_axi_rdata_o   (rdata),
    .s_axi_rresp_o   (rresp),
    .s_axi_rvalid_o  (rvalid),
    .s_axi_rready_i  (rready),
    .resolution_o    (resolution),
    .req_o           (req),
    .valid_i         (valid_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_unmapped(input logic [10:0] a);
    return (a & ~11'h00C) != 11'h000;
  endfunction

  // Model of a write: returns the expected response, reports whether req_o pulses.
  function automatic logic [1:0] m_write(input logic [10:0] a, input logic [31:0] d,
                                         input logic [3:0] s, output bit pulse);
    logic [1:0] word;
    pulse = 1'b0;
    if (is_unmapped(a)) return AXI_RESP_SLVERR;
    word = a[3:2];
    case (word)
      2'd0: begin
        if (!s[0]) return AXI_RESP_OKAY;
        if (32'(d[3:0]) >= VGA_RES_NUM) return AXI_RESP_SLVERR;
        m_res = d[3:0];
        return AXI_RESP_OKAY;
      end
      2'd1: begin
        if (!s[0]) return AXI_RESP_OKAY;
        if (m_busy) return AXI_RESP_SLVERR;
        if (d[0]) begin
          m_busy = 1'b1;
          pulse  = 1'b1;
        end
        return AXI_RESP_OKAY;
      end
      2'd2: begin
        if (s[0] && d[1]) m_done = 1'b0;
        return AXI_RESP_OKAY;
      end
      default: return AXI_RESP_SLVERR;
    endcase
  endfunction

  function automatic void m_valid();
    m_busy = 1'b0;
    m_done = 1'b1;
  endfunction

  function automatic void m_read(input logic [10:0] a, output logic [31:0] d, output logic [1:0] r);
    d = 32'h0;
    r = AXI_RESP_OKAY;
    if (is_unmapped(a)) begin
      r = AXI_RESP_SLVERR;
      return;
    end
    if (a[3:2] == 2'd0) d = {28'h0, m_res};
    else if (a[3:2] == 2'd2) d = {30'h0, m_done, m_busy};
    else if (a[3:2] == 2'd3) d = 32'h5647_4131;
  endfunction

  // Drive one write; AW and W each appear after their own delay in cycles.
  task automatic bus_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit pv, input int unsigned adly, input int unsigned wdly,
                           input logic [1:0] exp_resp, input bit exp_pulse);
    bit aw_done;
    bit w_done;
    int unsigned n;
    aw_done = 1'b0;
    w_done  = 1'b0;
    n       = 0;
    @(negedge clk);
    awaddr   = a;
    wdata    = d;
    wstrb    = s;
    bready   = 1'b1;
    valid_in = pv;
    while (!(aw_done && w_done) && n < 32) begin
      awvalid = !aw_done && (n >= adly);
      wvalid  = !w_done && (n >= wdly);
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready) w_done = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      n++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk("wr_accept", {31'h0, aw_done && w_done}, 32'h1);
    chk("wr_bvalid", {31'h0, bvalid}, 32'h1);
    chk("wr_bresp", {30'h0, bresp}, {30'h0, exp_resp});
    chk("wr_req_pulse", {31'h0, req}, {31'h0, exp_pulse});
    @(negedge clk);
    chk("wr_bvalid_drop", {31'h0, bvalid}, 32'h0);
    chk("wr_req_single", {31'h0, req}, 32'h0);
  endtask

  task automatic bus_read(input logic [10:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
    @(negedge clk);
    araddr  = a;
    arvalid = 1'b1;
    rready  = 1'b1;
    chk("rd_arready", {31'h0, arready}, 32'h1);
    @(negedge clk);
    arvalid = 1'b0;
    chk("rd_rvalid", {31'h0, rvalid}, 32'h1);
    chk("rd_rdata", rdata, exp_d);
    chk("rd_rresp", {30'h0, rresp}, {30'h0, exp_r});
    @(negedge clk);
    chk("rd_rvalid_drop", {31'h0, rvalid}, 32'h0);
  endtask

  task automatic wr(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s,
                    input bit pv, input int unsigned adly, input int unsigned wdly);
    logic [1:0] er;
    bit         ep;
    er = m_write(a, d, s, ep);
    if (pv) m_valid();
    bus_write(a, d, s, pv, adly, wdly, er, ep);
  endtask

  task automatic rd(input logic [10:0] a);
    logic [31:0] ed;
    logic [1:0]  er;
    m_read(a, ed, er);
    bus_read(a, ed, er);
  endtask

  initial begin
    logic [10:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int unsigned op;
    int unsigned k;

    arstn = 1'b0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1; valid_in = 1'b0;
    m_res = 4'd0; m_busy = 1'b0; m_done = 1'b0;
    repeat (3) @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_awready", {31'h0, awready}, 32'h1);
    chk("rst_wready", {31'h0, wready}, 32'h1);
    chk("rst_arready", {31'h0, arready}, 32'h1);
    chk("rst_bvalid", {31'h0, bvalid}, 32'h0);
    chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst_bresp", {30'h0, bresp}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_req", {31'h0, req}, 32'h0);
    chk("rst_resolution", 32'(resolution), 32'(VGA_RES_800_600));

    // ID and resolution control
    rd(11'h00C);
    wr(11'h000, 32'h1, 4'hF, 1'b0, 0, 0);
    rd(11'h000);
    chk("res_1280", 32'(resolution), 32'(VGA_RES_1280_1024));
    wr(11'h000, 32'hF, 4'hF, 1'b0, 0, 0);
    rd(11'h000);

    // Command, busy rejection, completion and W1C
    wr(11'h004, 32'h1, 4'hF, 1'b0, 0, 0);
    rd(11'h008);
    wr(11'h004, 32'h1, 4'hF, 1'b0, 0, 0);
    @(negedge clk); valid_in = 1'b1; m_valid();
    @(negedge clk); valid_in = 1'b0;
    rd(11'h008);
    wr(11'h008, 32'h2, 4'hF, 1'b0, 0, 0);
    rd(11'h008);

    // W three cycles ahead of AW, bready held low five cycles
    begin
      bit ep;
      logic [1:0] er;
      er = m_write(11'h000, 32'h2, 4'hF, ep);
      @(negedge clk);
      bready = 1'b0; wdata = 32'h2; wstrb = 4'hF; wvalid = 1'b1; awaddr = 11'h000;
      @(negedge clk);
      wvalid = 1'b0;
      chk("skew_wready_low", {31'h0, wready}, 32'h0);
      chk("skew_awready_high", {31'h0, awready}, 32'h1);
      chk("skew_no_bvalid", {31'h0, bvalid}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
        chk("skew_bvalid_hold", {31'h0, bvalid}, 32'h1);
        chk("skew_awready_low", {31'h0, awready}, 32'h0);
        chk("skew_wready_low2", {31'h0, wready}, 32'h0);
        @(negedge clk);
      end
      chk("skew_bresp", {30'h0, bresp}, {30'h0, er});
      bready = 1'b1;
      @(negedge clk);
      chk("skew_bvalid_done", {31'h0, bvalid}, 32'h0);
      chk("skew_ready_back", {30'h0, awready, wready}, 32'h3);
      rd(11'h000);
    end

    // Unmapped read, then completion racing DONE W1C and CMD
    rd(11'h010);
    wr(11'h004, 32'h1, 4'hF, 1'b0, 0, 0);
    wr(11'h008, 32'h2, 4'hF, 1'b1, 0, 0);
    rd(11'h008);
    wr(11'h004, 32'h1, 4'hF, 1'b0, 0, 0);
    wr(11'h004, 32'h1, 4'hF, 1'b1, 0, 0);
    rd(11'h008);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 9);
      k  = $urandom_range(0, 4);
      if (k < 4) begin
        a = 11'(k * 4);
      end else begin
        a = 11'($urandom);
        if (!is_unmapped(a)) a = a | 11'h010;
      end
      if (op <= 4) begin
        d = $urandom;
        if ($urandom_range(0, 1) == 1) d[3:0] = 4'($urandom_range(0, 3));
        s = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) s[0] = 1'b1;
        wr(a, d, s, 1'b0, $urandom_range(0, 2), $urandom_range(0, 2));
      end else if (op <= 8) begin
        rd(a);
      end else begin
        @(negedge clk); valid_in = 1'b1; m_valid();
        @(negedge clk); valid_in = 1'b0;
      end
    end

    // Reset while a write response is pending
    wr(11'h000, 32'h0, 4'hF, 1'b0, 0, 0);
    @(negedge clk);
    bready = 1'b0; awaddr = 11'h000; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("arst_pre_bvalid", {31'h0, bvalid}, 32'h1);
    chk("arst_pre_res", 32'(resolution), 32'd3);
    #2 arstn = 1'b0;
    #1;
    chk("arst_bvalid", {31'h0, bvalid}, 32'h0);
    chk("arst_readies", {29'h0, awready, wready, arready}, 32'h7);
    chk("arst_resolution", 32'(resolution), 32'(VGA_RES_800_600));
    @(negedge clk);
    arstn = 1'b1; bready = 1'b1;
    m_res = 4'd0; m_busy = 1'b0; m_done = 1'b0;
    rd(11'h000);
    rd(11'h008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
